// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-read-port register file
//
// Sits between decode (read ports) and writeback (write port). Adds
// byte-masked writes, an optional write-through bypass, a per-register
// pending-load scoreboard and a sequential clear engine that zeroes one entry
// per cycle after reset or on request.
//
// Ports:
//   clk, resetn      clock; synchronous active-low reset
//   clr_req          re-clear request, honoured only when idle
//   busy             high while the clear engine runs (issue must stall)
//   rd_addr/rd_data  NUM_RD packed read ports, combinational
//   rd_pend          per-port "addressed register has an outstanding load"
//   we/waddr/wdata   write port, wmask = per-byte enables
//   pend_set/pend_addr  mark a register as having a load in flight
//   dbg_state        current FSM state (0 = CLEAR, 1 = IDLE)
//
// Handshake: there is no valid/ready pair here. A write or pend_set is
// accepted on any rising edge while busy is low; while busy is high they are
// dropped, so the controller must hold issue until busy falls.
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wmask,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic                     dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pend, pend_nxt;

  logic                clr_go;
  logic                wr_ok;
  logic                ps_ok;
  logic                byp_en;
  logic [DATA_W-1:0]   merged;

  // A clear request wins over a same-cycle write/pend_set: everything is
  // about to be zeroed anyway.
  assign clr_go = (state == ST_IDLE) && clr_req;
  assign wr_ok  = (state == ST_IDLE) && !clr_req && we &&
                  !((ZERO_REG != 0) && (waddr == '0));
  assign ps_ok  = (state == ST_IDLE) && !clr_req && pend_set &&
                  !((ZERO_REG != 0) && (pend_addr == '0));
  assign byp_en = (BYPASS != 0) && (state == ST_IDLE) && we;

  assign busy      = (state == ST_CLEAR);
  assign dbg_state = state;

  // Value entry[waddr] will hold after the edge: masked bytes from wdata.
  always_comb begin
    merged = mem[waddr];
    for (int b = 0; b < NB; b++) begin
      if (wmask[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // FSM next state and clear counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (&cnt) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Scoreboard: a write clears the bit, then pend_set sets it, so a new
  // load issued in the same cycle as the write leaves the register pending.
  always_comb begin
    pend_nxt = pend;
    if (clr_go) begin
      pend_nxt = '0;
    end else begin
      if (wr_ok) pend_nxt[waddr] = 1'b0;
      if (ps_ok) pend_nxt[pend_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  // Storage has no reset of its own; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == ST_CLEAR) mem[cnt] <= '0;
      else if (wr_ok)        mem[waddr] <= merged;
    end
  end

  // Read ports: zero during reset/clear and for the hardwired zero register;
  // a matching same-cycle write is forwarded when bypass is enabled.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    rd_data = '0;
    rd_pend = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (resetn && (state == ST_IDLE) && !((ZERO_REG != 0) && (ra == '0))) begin
        if (byp_en && (ra == waddr)) begin
          rd_data[k*DATA_W +: DATA_W] = merged;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = mem[ra];
          rd_pend[k]                  = pend[ra];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port general-purpose register file for the multicycle CPU.
- Successor to the fixed 32x32 two-read-port register file. Adds:
  - configurable width, depth and read-port count;
  - byte-masked writes;
  - write-through bypass;
  - a per-register pending-load scoreboard;
  - a sequential clear engine that zeroes storage one entry per cycle after reset or on request.
- Sits between decode (read ports) and writeback (write port); the controller stalls issue while `busy` is high.

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a same-cycle write is visible on the read ports; 0 = reads return stored contents only.
- ZERO_REG, 1: 1 = entry 0 is hardwired to zero, never writable, never pending.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- clr_req  in  1  single-cycle request to re-clear all entries; honoured only in IDLE.
- busy  out  1  high while the clear engine runs.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; combinational, port k uses bits [k*DATA_W +: DATA_W].
- rd_pend  out  NUM_RD  per-port flag: the addressed register has an outstanding load.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wmask  in  DATA_W/8  byte enables; bit i enables byte [8i+7:8i].
- pend_set  in  1  mark register pend_addr pending (load issued).
- pend_addr  in  ADDR_W  register to mark pending.

Behaviour:
- Reset: resetn is synchronous and active-low; the clock is clk.
  - While resetn=0: state=CLEAR, clear counter=0, busy=1, all pending bits=0.
  - rd_data and rd_pend are forced to 0 on every port throughout reset.
- FSM states:
  - CLEAR: each edge writes entry[cnt]=0, then cnt++. On the edge that clears entry DEPTH-1, go to IDLE; busy falls after that edge.
  - Clear latency is exactly DEPTH edges after the first edge with resetn=1 (32 for defaults).
  - IDLE -> CLEAR on clr_req=1. The counter restarts at 0 and all pending bits are cleared on the same edge.
- Behaviour while in CLEAR:
  - we and pend_set are ignored.
  - rd_data=0 and rd_pend=0 on all ports.
  - clr_req is ignored.
  - resetn=0 mid-clear restarts the counter at 0.
- Write (IDLE only): when we=1, each byte of entry[waddr] with wmask[i]=1 takes wdata's byte; other bytes are unchanged. wmask=0 performs no data change but still clears pending.
  - When ZERO_REG=1, writes to waddr=0 are dropped entirely.
- Read, port k:
  - If ZERO_REG=1 and addr=0: rd_data=0 and rd_pend=0.
  - Else if BYPASS=1, we=1, state=IDLE and addr==waddr: rd_data = stored bytes merged with the masked wdata bytes (the value the entry will hold after the edge), and rd_pend=0.
  - Otherwise rd_data = stored entry and rd_pend = pending bit.
  - All ports are independent; several ports may read the same address.
- Scoreboard:
  - A write (we=1) to an address clears its pending bit.
  - pend_set sets the bit for pend_addr.
  - If we and pend_set target the same address in one cycle, the data is written and the bit ends SET (the new load takes precedence).
  - pend_set to address 0 is ignored when ZERO_REG=1.
- No read-port latency: all read outputs are combinational from the current state and inputs.

Test Plan:
- Release resetn after 3 cycles; check busy stays high for exactly 32 edges and then falls.
  - During the clear, set we=1, waddr=5, wdata=0xDEADBEEF; after busy falls, port0 reading addr 5 must return 0x00000000.
- In IDLE, write 0x11223344 to r7 with wmask=4'hF.
  - Next cycle write wdata=0xAABBCCDD with wmask=4'b0101; the same cycle port1 reading r7 must show 0x11BB33DD (bypass).
  - The following cycle the stored r7 must read 0x11BB33DD.
- Write 0xFFFFFFFF to r0; port0 reading r0 must return 0 during the write cycle and afterwards. Apply pend_set with pend_addr=0; rd_pend must stay 0.
- Assert pend_set for r9; ports 0 and 1 reading r9 must both show rd_pend=1.
  - Write r9; rd_pend must be 0 in the write cycle (bypass) and stay 0 afterwards.
  - Issue we and pend_set to r9 in the same cycle; rd_pend must be 1 after the edge.
- With registers holding non-zero data and r3 pending, pulse clr_req.
  - busy must rise the next cycle and stay high 32 edges.
  - All reads, including r3's rd_pend, must return 0 afterwards.
- Build with NUM_RD=3, BYPASS=0: a same-cycle write to r4 with all three ports on r4 must show the old value that cycle and the new value the next cycle.
